// File: rtl/pcmux.sv
// pcmux: next-PC select encoding shared by cpu_control and the fetch stage.
//   pc_plus4 - sequential fetch
//   alu_out  - branch/jump target straight from EX
//   alu_mod2 - JALR target with bit 0 cleared
package pcmux;

  typedef enum logic [1:0] {
    pc_plus4 = 2'b00,
    alu_out  = 2'b01,
    alu_mod2 = 2'b10
  } pcmux_sel_t;

endpackage

// File: rtl/rv32i_types.sv
// rv32i_types: shared RV32I pipeline types and constants.
//   fetch_state_t - IF stage FSM (read outstanding / word held)
//   RESET_PC      - first fetch address after reset
//   NOP           - addi x0,x0,0, used as the idle instruction word
package rv32i_types;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0060;
  localparam logic [31:0] NOP      = 32'h0000_0013;

endpackage

// File: rtl/fetch_next_pc.sv
// fetch_next_pc: combinational next-PC selection for the IF stage.
// Ports:
//   pc        in  32  current PC
//   pcmux_sel in  2   select from cpu_control (pcmux::pcmux_sel_t)
//   alu_out   in  32  branch/jump target from EX
//   next_pc   out 32  PC to commit when the pipeline advances
module fetch_next_pc (
  input  logic              [31:0] pc,
  input  pcmux::pcmux_sel_t        pcmux_sel,
  input  logic              [31:0] alu_out,
  output logic              [31:0] next_pc
);

  always_comb begin
    next_pc = pc + 32'd4;
    unique case (pcmux_sel)
      pcmux::pc_plus4: next_pc = pc + 32'd4;   // wraps naturally at 2^32
      pcmux::alu_out:  next_pc = alu_out;
      pcmux::alu_mod2: next_pc = alu_out & 32'hFFFF_FFFE;
      default:         next_pc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage of the 5-stage RV32I pipeline.
// Owns the PC, issues hold-until-resp reads to the I-cache, and presents a
// stable {pc, inst} pair to the IF/ID buffer. A response that arrives in the
// same cycle as load_buffers is bypassed straight through (zero-bubble hit);
// otherwise the word is captured and held until the pipeline advances.
// Ports:
//   clk              in  1   clock, rising edge
//   rst              in  1   asynchronous active-low reset
//   load_buffers     in  1   pipeline advance; commits next PC
//   pcmux_sel        in  2   next-PC select
//   alu_out          in  32  branch/jump target
//   inst_mem_address out 32  word-aligned fetch address
//   inst_mem_read    out 1   read request, held until inst_mem_resp
//   inst_mem_rdata   in  32  instruction word, valid with inst_mem_resp
//   inst_mem_resp    in  1   completion pulse
//   fetch_ready      out 1   instruction for current pc available
//   fetch_pc         out 32  PC of presented instruction
//   fetch_inst       out 32  presented instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC = rv32i_types::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_buffers,
  input  pcmux::pcmux_sel_t pcmux_sel,
  input  logic       [31:0] alu_out,
  output logic       [31:0] inst_mem_address,
  output logic              inst_mem_read,
  input  logic       [31:0] inst_mem_rdata,
  input  logic              inst_mem_resp,
  output logic              fetch_ready,
  output logic       [31:0] fetch_pc,
  output logic       [31:0] fetch_inst
);

  import rv32i_types::*;

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_inst_q;
  logic [31:0]  w_next_pc;
  logic         w_commit;
  logic         w_capture;

  fetch_next_pc u_next_pc (
    .pc        (r_pc),
    .pcmux_sel (pcmux_sel),
    .alu_out   (alu_out),
    .next_pc   (w_next_pc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_inst_q <= NOP;
    end else begin
      r_state <= w_state_next;
      if (w_commit)  r_pc     <= w_next_pc;
      if (w_capture) r_inst_q <= inst_mem_rdata;
    end
  end

  // Outputs are qualified by rst so the request drops the instant reset is
  // asserted, independent of the (also async) state register.
  always_comb begin
    w_state_next  = r_state;
    w_capture     = 1'b0;
    inst_mem_read = 1'b0;
    fetch_ready   = 1'b0;
    fetch_inst    = inst_mem_rdata;
    unique case (r_state)
      S_FETCH: begin
        inst_mem_read = rst;
        fetch_ready   = rst & inst_mem_resp;
        if (inst_mem_resp && !load_buffers) begin
          w_capture    = 1'b1;
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        fetch_ready = rst;
        fetch_inst  = r_inst_q;
        if (load_buffers) w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  // A load_buffers without a ready instruction is ignored (pc holds).
  assign w_commit         = load_buffers & fetch_ready;
  assign inst_mem_address = {r_pc[31:2], 2'b00};
  assign fetch_pc         = r_pc;

  a_no_early_advance: assert property (
    @(posedge clk) disable iff (!rst) load_buffers |-> fetch_ready);

  a_addr_stable: assert property (
    @(posedge clk) disable iff (!rst)
      (inst_mem_read && !inst_mem_resp) |=> $stable(inst_mem_address));

endmodule
